id_ex_stage: RTL and testbench

ID/EX pipeline register with EX-stage operand selection for the pipelined RV32I core. It latches decoded operands and control from the decode stage and applies stall and flush. It resolves data hazards by forwarding from the MEM and WB stages, then drives the two ALU operands and the ALU control code directly into the ALU. It also carries the store data and downstream control bits on to the EX/MEM register.

---
 rtl/id_ex_stage_pkg.sv | 46 ++++
 rtl/forwarding_unit.sv | 25 ++
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths, forward-select codes, stage payload types
// and the bubble helper for the ID/EX pipeline register.
// Optional feature macro used by importers: FORWARDING_EN.
package id_ex_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned FWD_W = 2;

  // Forward-select codes returned by forwarding_unit
  localparam logic [FWD_W-1:0] FWD_NONE = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB   = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;

  // Control bits that must be zero whenever the stage holds a bubble
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

  // Everything stored in the ID/EX register
  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [ALU_W-1:0]  alu_control;
    logic              alu_src;
    logic              alu_src_pc;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
  } id_ex_t;

  // Single definition of bubble-zeroing: control survives only for a real instruction
  function automatic ctrl_t bubble_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : '0;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: picks the forwarding source for one source register.
// Ports: rs (source index), mem_reg_write/mem_rd (EX/MEM writer),
//        wb_reg_write/wb_rd (MEM/WB writer), sel_c (FWD_* select code).
// MEM has priority over WB; index 0 never forwards.
module forwarding_unit
  import id_ex_stage_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  output logic [FWD_W-1:0] sel_c
);

  always_comb begin
    sel_c = FWD_NONE;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      sel_c = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-stage operand selection.
// Inputs : clk, reset (async, active-high), stall, flush, id_* decoded fields,
//          mem_* / wb_* forwarding sources.
// Outputs: alu_in_1/alu_in_2/alu_control to the ALU, ex_store_data and
//          ex_* control/index/pc/imm fields to the EX/MEM register.
// Macro  : FORWARDING_EN enables MEM/WB forwarding and sticky stall capture;
//          without it the operands come straight from the stored register data.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic [ALU_W-1:0] id_alu_control,
  input  logic             id_alu_src,
  input  logic             id_alu_src_pc,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_branch,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_write_data,
  output logic [XLEN-1:0]  alu_in_1,
  output logic [XLEN-1:0]  alu_in_2,
  output logic [ALU_W-1:0] alu_control,
  output logic [XLEN-1:0]  ex_store_data,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_branch,
  output logic [REG_W-1:0] ex_rd,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm
);

  id_ex_t           q;
  id_ex_t           d;
  ctrl_t            id_ctrl;
  logic [FWD_W-1:0] sel_rs1;
  logic [FWD_W-1:0] sel_rs2;
  logic [XLEN-1:0]  fwd_rs1;
  logic [XLEN-1:0]  fwd_rs2;

  assign id_ctrl = '{reg_write:  id_reg_write,
                     mem_read:   id_mem_read,
                     mem_write:  id_mem_write,
                     mem_to_reg: id_mem_to_reg,
                     branch:     id_branch};

  // Forward-source selection for each stored source register
  forwarding_unit u_fwd_rs1 (
    .rs            (q.rs1),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .sel_c         (sel_rs1)
  );

  forwarding_unit u_fwd_rs2 (
    .rs            (q.rs2),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .sel_c         (sel_rs2)
  );

  // Forwarded operand values
  always_comb begin
    fwd_rs1 = q.rs1_data;
    fwd_rs2 = q.rs2_data;
`ifdef FORWARDING_EN
    case (sel_rs1)
      FWD_MEM: fwd_rs1 = mem_alu_result;
      FWD_WB:  fwd_rs1 = wb_write_data;
      default: fwd_rs1 = q.rs1_data;
    endcase
    case (sel_rs2)
      FWD_MEM: fwd_rs2 = mem_alu_result;
      FWD_WB:  fwd_rs2 = wb_write_data;
      default: fwd_rs2 = q.rs2_data;
    endcase
`endif
  end

`ifndef FORWARDING_EN
  // Forwarding sources are intentionally ignored in this build
  logic unused_fwd;
  assign unused_fwd = ^{sel_rs1, sel_rs2, mem_alu_result, wb_write_data};
`endif

  // Next register contents: flush > stall > load
  always_comb begin
    d = q;
    if (flush) begin
      d = '0;
    end else if (!stall) begin
      d.valid       = id_valid;
      d.ctrl        = bubble_ctrl(id_ctrl, id_valid);
      d.alu_control = id_alu_control;
      d.alu_src     = id_alu_src;
      d.alu_src_pc  = id_alu_src_pc;
      d.rd          = id_rd;
      d.rs1         = id_rs1;
      d.rs2         = id_rs2;
      d.pc          = id_pc;
      d.imm         = id_imm;
      d.rs1_data    = id_rs1_data;
      d.rs2_data    = id_rs2_data;
    end
`ifdef FORWARDING_EN
    else begin
      // Sticky capture: a WB source may retire while we are stalled
      d.rs1_data = fwd_rs1;
      d.rs2_data = fwd_rs2;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

  assign alu_in_1      = q.alu_src_pc ? q.pc  : fwd_rs1;
  assign alu_in_2      = q.alu_src    ? q.imm : fwd_rs2;
  assign alu_control   = q.alu_control;
  assign ex_store_data = fwd_rs2;
  assign ex_valid      = q.valid;
  assign ex_reg_write  = q.ctrl.reg_write;
  assign ex_mem_read   = q.ctrl.mem_read;
  assign ex_mem_write  = q.ctrl.mem_write;
  assign ex_mem_to_reg = q.ctrl.mem_to_reg;
  assign ex_branch     = q.ctrl.branch;
  assign ex_rd         = q.rd;
  assign ex_pc         = q.pc;
  assign ex_imm        = q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage with a behavioural model
// checked every falling edge plus hand-computed literal expectations.
// Honours FORWARDING_EN the same way the design does.
module tb_id_ex_stage;

`ifdef FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_control;
  logic        id_alu_src, id_alu_src_pc;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_alu_result, wb_write_data;
  logic [31:0] alu_in_1, alu_in_2, ex_store_data, ex_pc, ex_imm;
  logic [3:0]  alu_control;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_alu_src(id_alu_src), .id_alu_src_pc(id_alu_src_pc), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_write_data(wb_write_data), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_control(alu_control), .ex_store_data(ex_store_data), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_rd(ex_rd),
    .ex_pc(ex_pc), .ex_imm(ex_imm)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 0, m_rw = 0, m_mr = 0, m_mw = 0, m_mtr = 0, m_br = 0;
  logic        m_src = 0, m_srcpc = 0;
  logic [3:0]  m_aluc = 0;
  logic [4:0]  m_rd = 0, m_rs1 = 0, m_rs2 = 0;
  logic [31:0] m_pc = 0, m_imm = 0, m_d1 = 0, m_d2 = 0;

  // Value an operand sees given its index and its stored data
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] data);
    if (FWD_ON && mem_reg_write && mem_rd != 5'd0 && mem_rd == idx) return mem_alu_result;
    if (FWD_ON && wb_reg_write && wb_rd != 5'd0 && wb_rd == idx) return wb_write_data;
    return data;
  endfunction

  task automatic model_clear();
    {m_valid, m_rw, m_mr, m_mw, m_mtr, m_br, m_src, m_srcpc} = '0;
    m_aluc = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    logic [31:0] n1, n2;
    if (reset || flush) begin
      model_clear();
    end else if (stall) begin
      if (FWD_ON) begin
        n1 = fwd(m_rs1, m_d1);
        n2 = fwd(m_rs2, m_d2);
        m_d1 = n1;
        m_d2 = n2;
      end
    end else begin
      m_valid = id_valid;
      m_rw  = id_valid & id_reg_write;
      m_mr  = id_valid & id_mem_read;
      m_mw  = id_valid & id_mem_write;
      m_mtr = id_valid & id_mem_to_reg;
      m_br  = id_valid & id_branch;
      m_src = id_alu_src; m_srcpc = id_alu_src_pc; m_aluc = id_alu_control;
      m_rd = id_rd; m_rs1 = id_rs1; m_rs2 = id_rs2;
      m_pc = id_pc; m_imm = id_imm; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
    end
  end

  // Compare every output against the model each falling edge
  always @(negedge clk) begin
    check("m_alu_in_1", alu_in_1, m_srcpc ? m_pc : fwd(m_rs1, m_d1));
    check("m_alu_in_2", alu_in_2, m_src ? m_imm : fwd(m_rs2, m_d2));
    check("m_store", ex_store_data, fwd(m_rs2, m_d2));
    check("m_alu_control", 32'(alu_control), 32'(m_aluc));
    check("m_ctrl", 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}),
          32'({m_valid, m_rw, m_mr, m_mw, m_mtr, m_br}));
    check("m_rd", 32'(ex_rd), 32'(m_rd));
    check("m_pc", ex_pc, m_pc);
    check("m_imm", ex_imm, m_imm);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {stall, flush, id_valid, id_alu_src, id_alu_src_pc} = '0;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = '0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_control = 0;
    mem_reg_write = 0; wb_reg_write = 0; mem_rd = 0; wb_rd = 0;
    mem_alu_result = 0; wb_write_data = 0;
  endtask

  initial begin
    clear_inputs();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_alu_in_1", alu_in_1, 32'd0);

    // MEM beats WB on rs1; rs2 uses stored data
    id_valid = 1; id_rs1 = 5; id_rs1_data = 32'h10; id_rs2 = 6; id_rs2_data = 32'h20;
    id_rd = 3; id_reg_write = 1; id_alu_control = 4'h2;
    mem_reg_write = 1; mem_rd = 5; mem_alu_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 5; wb_write_data = 32'hBB;
    tick();
    check("fwd_mem_alu_in_1", alu_in_1, FWD_ON ? 32'hAA : 32'h10);
    check("fwd_alu_in_2", alu_in_2, 32'h20);
    check("load_rd", 32'(ex_rd), 32'd3);
    check("load_alu_control", 32'(alu_control), 32'h2);
    mem_rd = 9;
    #1;
    check("fwd_wb_alu_in_1", alu_in_1, FWD_ON ? 32'hBB : 32'h10);

    // Index 0 never forwards
    id_rs1 = 0; id_rs1_data = 0; mem_rd = 0; mem_reg_write = 1; mem_alu_result = 32'hFF;
    wb_reg_write = 0; wb_rd = 0;
    tick();
    check("rd0_alu_in_1", alu_in_1, 32'd0);

    // Sticky capture across a stall while the WB source retires
    mem_reg_write = 0; id_rs2 = 7; id_rs2_data = 32'h55;
    wb_reg_write = 1; wb_rd = 7; wb_write_data = 32'h1234;
    tick();
    check("sticky_pre", ex_store_data, FWD_ON ? 32'h1234 : 32'h55);
    stall = 1; id_rs2_data = 32'h99; id_rd = 9;
    tick();
    wb_reg_write = 0;
    #1;
    check("sticky_1", ex_store_data, FWD_ON ? 32'h1234 : 32'h55);
    tick();
    check("sticky_2", ex_store_data, FWD_ON ? 32'h1234 : 32'h55);
    check("stall_rd_hold", 32'(ex_rd), 32'd3);
    stall = 0;

    // Flush beats stall
    stall = 1; flush = 1; id_valid = 1; id_reg_write = 1; id_mem_write = 1;
    tick();
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    check("flush_reg_write", 32'(ex_reg_write), 32'd0);
    check("flush_mem_write", 32'(ex_mem_write), 32'd0);
    stall = 0; flush = 0;

    // AUIPC operand selection
    clear_inputs();
    id_valid = 1; id_alu_src_pc = 1; id_pc = 32'h400; id_alu_src = 1; id_imm = 32'h1000;
    tick();
    check("auipc_alu_in_1", alu_in_1, 32'h400);
    check("auipc_alu_in_2", alu_in_2, 32'h1000);

    // Captured id_valid=0 is a bubble
    clear_inputs();
    id_reg_write = 1; id_mem_read = 1; id_branch = 1; id_rd = 4;
    tick();
    check("bubble_reg_write", 32'(ex_reg_write), 32'd0);
    check("bubble_mem_read", 32'(ex_mem_read), 32'd0);
    check("bubble_rd", 32'(ex_rd), 32'd4);

    // Directed pseudo-random traffic; the model checks every cycle
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_valid = 1'($urandom);
      {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = 5'($urandom);
      id_alu_src = 1'($urandom); id_alu_src_pc = 1'($urandom);
      id_alu_control = 4'($urandom);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom);
      id_pc = $urandom; id_imm = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
      mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 3)); mem_alu_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_write_data = $urandom;
      tick();
    end

    // Asynchronous reset mid-stream
    clear_inputs();
    id_valid = 1; id_reg_write = 1; id_rs1 = 3; id_rs1_data = 32'h77; id_pc = 32'h80; id_rd = 2;
    tick();
    check("pre_rst_alu_in_1", alu_in_1, 32'h77);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(ex_valid), 32'd0);
    check("async_rst_reg_write", 32'(ex_reg_write), 32'd0);
    check("async_rst_alu_in_1", alu_in_1, 32'd0);
    check("async_rst_pc", ex_pc, 32'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
